// File: rtl/spi_cmd_ctl.sv
// Command sequencer for one SPI chip-select window: the first byte selects the command,
// and the bytes after it go to the config registers or the pixel RAM, or end the frame.
module spi_cmd_ctl #(
  parameter int CFG_NUM = 6,
  parameter int PIX_NUM = 768,
  parameter int CFG_AW  = $clog2(CFG_NUM),
  parameter int PIX_AW  = $clog2(PIX_NUM)
) (
  input  logic              clk_in,
  input  logic              spi_rst_n,
  input  logic              byte_rdy_in,
  input  logic [7:0]        byte_data_in,
  output logic              cfg_wr_en_out,
  output logic [CFG_AW-1:0] cfg_wr_addr_out,
  output logic [7:0]        cfg_wr_data_out,
  output logic              pix_wr_en_out,
  output logic [PIX_AW-1:0] pix_wr_addr_out,
  output logic [7:0]        pix_wr_data_out,
  output logic              frame_done_out,
  output logic              overrun_out
);

  typedef enum logic [1:0] {IDLE, CFG, PIX, DROP} state_t;

  localparam logic [7:0]      CMD_CFG   = 8'h2A;
  localparam logic [7:0]      CMD_PIX   = 8'h2B;
  localparam logic [7:0]      CMD_FRAME = 8'h2C;
  localparam logic [PIX_AW:0] CFG_LIM   = CFG_NUM[PIX_AW:0];
  localparam logic [PIX_AW:0] PIX_LIM   = PIX_NUM[PIX_AW:0];
  localparam logic [PIX_AW:0] CNT_ONE   = (PIX_AW+1)'(1);

  state_t          state;
  logic [PIX_AW:0] cnt;

  always_ff @(posedge clk_in or negedge spi_rst_n) begin
    if (!spi_rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      cfg_wr_en_out   <= 1'b0;
      cfg_wr_addr_out <= '0;
      cfg_wr_data_out <= '0;
      pix_wr_en_out   <= 1'b0;
      pix_wr_addr_out <= '0;
      pix_wr_data_out <= '0;
      frame_done_out  <= 1'b0;
      overrun_out     <= 1'b0;
    end else begin
      cfg_wr_en_out  <= 1'b0;
      pix_wr_en_out  <= 1'b0;
      frame_done_out <= 1'b0;
      if (byte_rdy_in) begin
        case (state)
          IDLE: begin
            case (byte_data_in)
              CMD_CFG: begin
                state <= CFG;
                cnt   <= '0;
              end
              CMD_PIX: begin
                state <= PIX;
                cnt   <= '0;
              end
              CMD_FRAME: begin
                frame_done_out <= 1'b1;
                state          <= DROP;
              end
              default: state <= DROP;
            endcase
          end
          CFG: begin
            // The counter saturates at the limit, so excess bytes never wrap onto address 0.
            if (cnt < CFG_LIM) begin
              cfg_wr_en_out   <= 1'b1;
              cfg_wr_addr_out <= cnt[CFG_AW-1:0];
              cfg_wr_data_out <= byte_data_in;
              cnt             <= cnt + CNT_ONE;
            end else begin
              overrun_out <= 1'b1;
            end
          end
          PIX: begin
            if (cnt < PIX_LIM) begin
              pix_wr_en_out   <= 1'b1;
              pix_wr_addr_out <= cnt[PIX_AW-1:0];
              pix_wr_data_out <= byte_data_in;
              cnt             <= cnt + CNT_ONE;
            end else begin
              overrun_out <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctl.sv
// Scoreboard bench for spi_cmd_ctl: the driver queues each expected strobe with its
// expected cycle, and a negedge monitor checks every strobe the DUT raises.
module tb_spi_cmd_ctl;

  localparam int CFG_AW = 3;
  localparam int PIX_AW = 10;
  localparam logic [1:0] K_CFG = 2'd0, K_PIX = 2'd1, K_FRM = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [9:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } ev_t;

  logic              clk_in = 1'b0;
  logic              spi_rst_n = 1'b0;
  logic              byte_rdy_in = 1'b0;
  logic [7:0]        byte_data_in = '0;
  logic              cfg_wr_en_out;
  logic [CFG_AW-1:0] cfg_wr_addr_out;
  logic [7:0]        cfg_wr_data_out;
  logic              pix_wr_en_out;
  logic [PIX_AW-1:0] pix_wr_addr_out;
  logic [7:0]        pix_wr_data_out;
  logic              frame_done_out;
  logic              overrun_out;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  ev_t  sb[$];

  spi_cmd_ctl #(.CFG_NUM(6), .PIX_NUM(768)) dut (
    .clk_in(clk_in), .spi_rst_n(spi_rst_n),
    .byte_rdy_in(byte_rdy_in), .byte_data_in(byte_data_in),
    .cfg_wr_en_out(cfg_wr_en_out), .cfg_wr_addr_out(cfg_wr_addr_out),
    .cfg_wr_data_out(cfg_wr_data_out),
    .pix_wr_en_out(pix_wr_en_out), .pix_wr_addr_out(pix_wr_addr_out),
    .pix_wr_data_out(pix_wr_data_out),
    .frame_done_out(frame_done_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [9:0] a, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.cyc = 32'(cyc + 1);
    sb.push_back(e);
  endtask

  // Called at posedge+1: presents one byte for exactly one sampling edge.
  task automatic put(input logic [7:0] d);
    byte_rdy_in  = 1'b1;
    byte_data_in = d;
    @(posedge clk_in); #1;
  endtask

  task automatic idle(input int n);
    byte_rdy_in = 1'b0;
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic cs_cycle();
    idle(3);
    @(negedge clk_in); spi_rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    spi_rst_n = 1'b1;
    @(posedge clk_in); #1;
  endtask

  always @(negedge clk_in) begin
    ev_t act, exp;
    int  n;
    if (spi_rst_n) begin
      n = int'(cfg_wr_en_out) + int'(pix_wr_en_out) + int'(frame_done_out);
      if (n != 0) begin
        if (n > 1) check("strobe_onehot", 32'(n), 32'd1);
        act.kind = cfg_wr_en_out ? K_CFG : (pix_wr_en_out ? K_PIX : K_FRM);
        act.addr = cfg_wr_en_out ? 10'(cfg_wr_addr_out) : (pix_wr_en_out ? pix_wr_addr_out : '0);
        act.data = cfg_wr_en_out ? cfg_wr_data_out : (pix_wr_en_out ? pix_wr_data_out : '0);
        act.cyc  = 32'(cyc);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe: got kind=%0d addr=%0d data=%0h cyc=%0d required none",
                   act.kind, act.addr, act.data, act.cyc);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            failures++;
            $display("FAIL strobe: got kind=%0d addr=%0d data=%0h cyc=%0d required kind=%0d addr=%0d data=%0h cyc=%0d",
                     act.kind, act.addr, act.data, act.cyc, exp.kind, exp.addr, exp.data, exp.cyc);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] outs_or;
    #23;
    check("reset_cfg_en", 32'(cfg_wr_en_out), 0);
    check("reset_pix_en", 32'(pix_wr_en_out), 0);
    check("reset_frame", 32'(frame_done_out), 0);
    check("reset_overrun", 32'(overrun_out), 0);
    check("reset_addr_data", 32'({cfg_wr_addr_out, pix_wr_addr_out, cfg_wr_data_out, pix_wr_data_out}), 0);
    @(negedge clk_in); spi_rst_n = 1'b1;
    @(posedge clk_in); #1;

    // Full config payload, with gaps between bytes.
    put(8'h2A);
    for (int i = 0; i < 6; i++) begin
      expect_ev(K_CFG, 10'(i), 8'h11 + 8'(i));
      put(8'h11 + 8'(i));
      idle(1);
    end
    check("cfg6_overrun", 32'(overrun_out), 0);
    cs_cycle();

    // Config with one excess byte, back-to-back, payload right after command.
    put(8'h2A);
    for (int i = 0; i < 6; i++) begin
      expect_ev(K_CFG, 10'(i), 8'hC0 + 8'(i));
      put(8'hC0 + 8'(i));
    end
    check("cfg7_overrun_before", 32'(overrun_out), 0);
    put(8'hEE);
    check("cfg7_overrun_after", 32'(overrun_out), 1);
    idle(2);
    check("cfg7_overrun_sticky", 32'(overrun_out), 1);
    cs_cycle();
    check("overrun_cleared_by_reset", 32'(overrun_out), 0);

    // Full pixel payload back-to-back, then one excess byte.
    put(8'h2B);
    for (int i = 0; i < 768; i++) begin
      expect_ev(K_PIX, 10'(i), i[7:0]);
      put(i[7:0]);
    end
    check("pix_overrun_before", 32'(overrun_out), 0);
    put(8'h5A);
    check("pix_overrun_after", 32'(overrun_out), 1);
    idle(2);
    check("pix_addr_held", 32'(pix_wr_addr_out), 767);
    cs_cycle();

    // Frame done, then later bytes dropped.
    expect_ev(K_FRM, '0, '0);
    put(8'h2C);
    put(8'h2B);
    put(8'h55);
    idle(2);
    check("frame_no_overrun", 32'(overrun_out), 0);
    cs_cycle();

    // Chip select released mid-payload.
    put(8'h2B);
    expect_ev(K_PIX, 10'd0, 8'hAA);
    put(8'hAA);
    expect_ev(K_PIX, 10'd1, 8'hBB);
    put(8'hBB);
    byte_rdy_in = 1'b0;
    @(negedge clk_in); #1;
    check("pre_reset_pix_data", 32'(pix_wr_data_out), 32'hBB);
    spi_rst_n = 1'b0;
    #1;
    outs_or = 8'({cfg_wr_en_out, pix_wr_en_out, frame_done_out, overrun_out}) |
              8'(|{cfg_wr_addr_out, pix_wr_addr_out, cfg_wr_data_out, pix_wr_data_out});
    check("async_reset_outputs", 32'(outs_or), 0);
    repeat (2) @(negedge clk_in);
    spi_rst_n = 1'b1;
    @(posedge clk_in); #1;
    put(8'h2A);
    expect_ev(K_CFG, 10'd0, 8'h01);
    put(8'h01);
    idle(2);
    cs_cycle();

    // Unknown command.
    put(8'h00);
    for (int i = 0; i < 4; i++) put(8'h2A + 8'(i));
    idle(2);
    check("unknown_overrun", 32'(overrun_out), 0);

    idle(3);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctl.md
# spi_cmd_ctl

Command sequencer between the SPI byte receiver and the LED controller storage. Consumes the `byte_rdy`/`byte_data` stream produced during one chip-select window and decodes the first byte as a command. It then steers the following bytes into the configuration register file or the pixel RAM write port, or issues a frame-done strobe. The whole block is reset at every chip-select deassertion, so each SPI transaction is one self-contained command.

## Interface
- `CFG_NUM`, 6: number of configuration bytes accepted by CFG_WR.
- `PIX_NUM`, 768: number of pixel bytes accepted by PIX_WR (256 LEDs x 3).
- `CFG_AW`, $clog2(CFG_NUM): config address width.
- `PIX_AW`, $clog2(PIX_NUM): pixel address width.

Ports:
- `clk_in`  in  1  system clock.
- `spi_rst_n`  in  1  reset. Asynchronous, active-low; clock `clk_in`. Asserted whenever chip select is inactive.
- `byte_rdy_in`  in  1  one-cycle strobe; `byte_data_in` is valid in that cycle.
- `byte_data_in`  in  8  received byte.
- `cfg_wr_en_out`  out  1  config write strobe.
- `cfg_wr_addr_out`  out  CFG_AW  config write address.
- `cfg_wr_data_out`  out  8  config write data.
- `pix_wr_en_out`  out  1  pixel RAM write strobe.
- `pix_wr_addr_out`  out  PIX_AW  pixel RAM write address.
- `pix_wr_data_out`  out  8  pixel RAM write data.
- `frame_done_out`  out  1  one-cycle strobe: frame is complete and ready to refresh.
- `overrun_out`  out  1  sticky: a data byte arrived after the command's byte limit.

## Operation
- States:
  - IDLE: awaiting command byte.
  - CFG: config payload.
  - PIX: pixel payload.
  - DROP: discard until reset.
- IDLE, on `byte_rdy_in`:
  - 0x2A: go to CFG and clear the payload counter.
  - 0x2B: go to PIX and clear the payload counter.
  - 0x2C: pulse `frame_done_out` and go to DROP.
  - Any other value: go to DROP with no output activity.
- CFG, on `byte_rdy_in`:
  - If counter < CFG_NUM: write the byte at addr = counter, then increment the counter.
  - Otherwise: no write, set `overrun_out`, stay in CFG.
- PIX: same rules as CFG, using PIX_NUM and the pixel port. The counter never wraps: byte PIX_NUM+1 does not overwrite address 0.
- DROP: ignore all bytes. `overrun_out` is not set.
- The payload counter is a single register sized to hold PIX_NUM (width PIX_AW+1) and is shared by CFG and PIX. Config addresses use the low CFG_AW bits.
- Only one of `cfg_wr_en_out`, `pix_wr_en_out` and `frame_done_out` is high in any cycle.
- Reset mid-operation (CS released mid-payload):
  - All outputs return to 0 immediately and the state returns to IDLE.
  - Bytes already written stay in the external storage.
  - The next transaction is parsed from its first byte.
- No state persists across transactions. Persistent configuration lives in the external register file.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- All outputs are registered.
- Write strobes and `frame_done_out`:
  - Assert exactly in the cycle after the `byte_rdy_in` that caused them.
  - Stay high for exactly one cycle.
  - Address and data are valid in the same cycle as the strobe.
- Address and data outputs hold their last value while the strobe is low.
- `byte_rdy_in` may be high on consecutive cycles. Each one yields one write in the following cycle, with no lost bytes.
- `overrun_out` rises in the cycle after the first excess byte and holds until reset.
- Command decode latency is one cycle. A payload byte arriving in the cycle right after the command byte is accepted as payload index 0.

## Test plan
- Send 0x2A, 0x11..0x16 -> six `cfg_wr_en_out` pulses, addr 0..5, data 0x11..0x16, each one cycle after its rdy. `overrun_out` = 0.
- Send 0x2A plus seven bytes -> six writes; the 7th byte gives no write, and `overrun_out` = 1 from the cycle after it.
- Send 0x2B plus 768 bytes (data = index & 0xFF) on back-to-back `byte_rdy_in` -> 768 `pix_wr_en_out` pulses, addr 0..767. Then one extra byte -> no write, `overrun_out` = 1, addr 0 not rewritten.
- Send 0x2C, then 0x2B, 0x55 -> exactly one `frame_done_out` pulse, one cycle after the first rdy, and no pixel writes.
- Send 0x2B, 0xAA, 0xBB, then assert `spi_rst_n` low between the 2nd and 3rd byte, release, and send 0x2A, 0x01 -> pixel writes addr 0=0xAA, 1=0xBB. Outputs go to 0 asynchronously. Then one config write, addr 0 = 0x01.
- Send unknown command 0x00 plus 4 bytes -> no strobes; `overrun_out` = 0.
